trace_neuron: RTL and testbench

- Consumes the decaying trace vector from a bank of upstream per-input tracers and computes a weighted sum on request.
- Snapshots the traces, runs a serial multiply-accumulate (one input per clock), and compares the sum against an adaptive threshold.
- Emits a single-cycle spike and done pulse. It is the first decision stage between the tracer bank and the classifier/winner-take-all logic.

---
 rtl/trace_neuron_if.sv | 28 ++
 rtl/trace_neuron.sv | 153 +++++++++++++++
 tb/tb_trace_neuron.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/trace_neuron_if.sv
// Request/result bundle between the tracer bank, the trace neuron and downstream logic.
interface trace_neuron_if #(
  parameter int unsigned p_width     = 8,
  parameter int unsigned p_inputs    = 4,
  parameter int unsigned p_wwidth    = 8,
  parameter int unsigned p_acc_width = 18
);
  logic                            i_start;
  logic [p_inputs*p_width-1:0]     i_trace;
  logic [p_inputs*p_wwidth-1:0]    i_weight;
  logic                            i_thr_load;
  logic [p_acc_width-1:0]          i_thr_init;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_spike;
  logic [p_acc_width-1:0]          o_sum;
  logic [p_acc_width-1:0]          o_threshold;

  modport master (
    output i_start, i_trace, i_weight, i_thr_load, i_thr_init,
    input  o_busy, o_done, o_spike, o_sum, o_threshold
  );

  modport slave (
    input  i_start, i_trace, i_weight, i_thr_load, i_thr_init,
    output o_busy, o_done, o_spike, o_sum, o_threshold
  );
endinterface

// File: rtl/trace_neuron.sv
// Snapshots a trace vector, accumulates trace*weight serially with saturation,
// then compares against a self-adapting threshold and pulses done/spike.
module trace_neuron #(
  parameter int unsigned p_width     = 8,
  parameter int unsigned p_inputs    = 4,
  parameter int unsigned p_wwidth    = 8,
  parameter int unsigned p_acc_width = 18,
  parameter int unsigned p_thr_reset = 500,
  parameter int unsigned p_thr_inc   = 16,
  parameter int unsigned p_thr_dec   = 1,
  parameter int unsigned p_thr_min   = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  trace_neuron_if.slave   bus
);

  localparam int unsigned c_tw  = p_inputs * p_width;
  localparam int unsigned c_ww  = p_inputs * p_wwidth;
  localparam int unsigned c_pw  = p_width + p_wwidth;
  localparam int unsigned c_sw  = ((p_acc_width > c_pw) ? p_acc_width : c_pw) + 1;
  localparam int unsigned c_iw  = (p_inputs > 1) ? $clog2(p_inputs) : 1;
  localparam int unsigned c_tx  = p_acc_width + 1;

  localparam logic [p_acc_width-1:0] c_acc_max   = '1;
  localparam logic [p_acc_width-1:0] c_thr_reset = p_acc_width'(p_thr_reset);
  localparam logic [p_acc_width-1:0] c_thr_dec   = p_acc_width'(p_thr_dec);
  localparam logic [p_acc_width-1:0] c_thr_min   = p_acc_width'(p_thr_min);
  localparam logic [p_acc_width-1:0] c_thr_lim   = p_acc_width'(p_thr_min + p_thr_dec);
  localparam logic [c_iw-1:0]        c_idx_last  = c_iw'(p_inputs - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_start_acc;

  logic [c_tw-1:0]         r_trace_snap;
  logic [c_ww-1:0]         r_weight_snap;
  logic [c_iw-1:0]         r_idx;
  logic [p_acc_width-1:0]  r_acc;
  logic [p_acc_width-1:0]  r_sum;
  logic [p_acc_width-1:0]  r_thr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_spike;

  logic [p_width-1:0]      w_trace_k;
  logic [p_wwidth-1:0]     w_weight_k;
  logic [c_pw-1:0]         w_prod;
  logic [c_sw-1:0]         w_sum_ext;
  logic [p_acc_width-1:0]  w_acc_sat;
  logic                    w_spike;
  logic [c_tx-1:0]         w_thr_up_ext;
  logic [p_acc_width-1:0]  w_thr_up;
  logic [p_acc_width-1:0]  w_thr_dn;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (r_idx == c_idx_last) w_state_nxt = S_CMP;
      end
      S_CMP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One MAC term per cycle, clamped to the accumulator range
  always_comb begin
    w_trace_k  = r_trace_snap[int'(r_idx) * p_width +: p_width];
    w_weight_k = r_weight_snap[int'(r_idx) * p_wwidth +: p_wwidth];
    w_prod     = c_pw'(w_trace_k) * c_pw'(w_weight_k);
    w_sum_ext  = c_sw'(r_acc) + c_sw'(w_prod);
    w_acc_sat  = (w_sum_ext > c_sw'(c_acc_max)) ? c_acc_max : w_sum_ext[p_acc_width-1:0];
  end

  // Threshold adaptation candidates; spike compares against the current threshold
  always_comb begin
    w_spike      = (r_acc >= r_thr);
    w_thr_up_ext = c_tx'(r_thr) + c_tx'(p_thr_inc);
    w_thr_up     = w_thr_up_ext[c_tx-1] ? c_acc_max : w_thr_up_ext[p_acc_width-1:0];
    w_thr_dn     = (r_thr >= c_thr_lim) ? (r_thr - c_thr_dec) : c_thr_min;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trace_snap  <= '0;
      r_weight_snap <= '0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_sum         <= '0;
      r_thr         <= c_thr_reset;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_spike       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_spike <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= w_start_acc;
          if (w_start_acc) begin
            r_trace_snap  <= bus.i_trace;
            r_weight_snap <= bus.i_weight;
            r_idx         <= '0;
            r_acc         <= '0;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_sat;
          r_idx <= r_idx + c_iw'(1);
        end
        S_CMP: begin
          r_sum   <= r_acc;
          r_done  <= 1'b1;
          r_spike <= w_spike;
        end
        default: r_busy <= 1'b0;
      endcase

      // An external load overrides adaptation in the same cycle
      if (bus.i_thr_load)        r_thr <= bus.i_thr_init;
      else if (r_state == S_CMP) r_thr <= w_spike ? w_thr_up : w_thr_dn;
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_spike     = r_spike;
  assign bus.o_sum       = r_sum;
  assign bus.o_threshold = r_thr;

endmodule

// File: tb/tb_trace_neuron.sv
// Scoreboard bench for trace_neuron: stimulus pushes expected results, a monitor checks each done pulse.
module tb_trace_neuron;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned A  = 18;
  localparam int unsigned AS = 10;
  localparam int          ACC_MAX = (1 << A) - 1;

  typedef int vec_t [4];
  typedef struct {
    int sum;
    int spike;
    int thr;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_neuron_if #(.p_width(W), .p_inputs(N), .p_wwidth(WW), .p_acc_width(A))  bus ();
  trace_neuron_if #(.p_width(W), .p_inputs(N), .p_wwidth(WW), .p_acc_width(AS)) bus_s ();

  trace_neuron #(.p_width(W), .p_inputs(N), .p_wwidth(WW), .p_acc_width(A),
                 .p_thr_reset(500), .p_thr_inc(16), .p_thr_dec(1), .p_thr_min(64))
    u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  trace_neuron #(.p_width(W), .p_inputs(N), .p_wwidth(WW), .p_acc_width(AS),
                 .p_thr_reset(500), .p_thr_inc(16), .p_thr_dec(1), .p_thr_min(64))
    u_sat (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_s));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   thr_m = 500;
  int   issued = 0;
  int   done_cnt = 0;
  exp_t exp_q [$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer dot product clamped to the accumulator range
  function automatic int model_sum(input vec_t t, input vec_t w);
    int s = 0;
    for (int k = 0; k < 4; k++) s += t[k] * w[k];
    return (s > ACC_MAX) ? ACC_MAX : s;
  endfunction

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        done_cnt++;
        chk("sum", int'(bus.o_sum), mon_e.sum);
        chk("spike", int'(bus.o_spike), mon_e.spike);
        chk("threshold", int'(bus.o_threshold), mon_e.thr);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is visible
  task automatic run_eval(input vec_t t, input vec_t w, input bit mutate, input bit poke,
                          input bit load_cmp, input int load_val);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      bus.i_trace[k*W +: W]   = W'(t[k]);
      bus.i_weight[k*WW +: WW] = WW'(w[k]);
    end
    bus.i_start = 1'b1;
    e.sum   = model_sum(t, w);
    e.spike = (e.sum >= thr_m) ? 1 : 0;
    if (load_cmp)     e.thr = load_val;
    else if (e.spike) e.thr = (thr_m + 16 > ACC_MAX) ? ACC_MAX : thr_m + 16;
    else              e.thr = (thr_m - 1 < 64) ? 64 : thr_m - 1;
    thr_m = e.thr;
    e.cyc = cyc + 6;
    exp_q.push_back(e);
    issued++;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("busy_acc", int'(bus.o_busy), 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mutate) begin
        bus.i_trace  = 32'($urandom);
        bus.i_weight = 32'($urandom);
      end
      bus.i_start = poke && (i == 1);
      if (i == 4 && load_cmp) begin
        bus.i_thr_load = 1'b1;
        bus.i_thr_init = A'(load_val);
      end
    end
    @(negedge clk);
    bus.i_thr_load = 1'b0;
  endtask

  task automatic load_thr(input int v);
    bus.i_thr_load = 1'b1;
    bus.i_thr_init = A'(v);
    @(negedge clk);
    bus.i_thr_load = 1'b0;
    thr_m = v;
    chk("thr_load", int'(bus.o_threshold), v);
  endtask

  task automatic sat_eval(input int exp_thr);
    bus_s.i_trace  = '1;
    bus_s.i_weight = '1;
    bus_s.i_start  = 1'b1;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    for (int i = 0; i < 20 && bus_s.o_done !== 1'b1; i++) @(negedge clk);
    chk("sat_done", int'(bus_s.o_done), 1);
    chk("sat_sum", int'(bus_s.o_sum), 1023);
    chk("sat_spike", int'(bus_s.o_spike), 1);
    chk("sat_thr", int'(bus_s.o_threshold), exp_thr);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t, w;
    int   saved_done;
    bus.i_start = 1'b0;   bus.i_trace = '0;   bus.i_weight = '0;
    bus.i_thr_load = 1'b0; bus.i_thr_init = '0;
    bus_s.i_start = 1'b0; bus_s.i_trace = '0; bus_s.i_weight = '0;
    bus_s.i_thr_load = 1'b0; bus_s.i_thr_init = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_threshold", int'(bus.o_threshold), 500);
    chk("rst_sum", int'(bus.o_sum), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_spike", int'(bus.o_spike), 0);

    // Directed: miss, spike, floor, zero traces, sub-floor load
    run_eval('{10, 20, 0, 0}, '{3, 4, 0, 0}, 0, 0, 0, 0);
    load_thr(500);
    run_eval('{255, 0, 0, 0}, '{2, 0, 0, 0}, 0, 0, 0, 0);
    load_thr(64);
    run_eval('{0, 0, 0, 0}, '{9, 9, 9, 9}, 0, 0, 0, 0);
    load_thr(0);
    run_eval('{0, 0, 0, 0}, '{5, 5, 5, 5}, 0, 0, 0, 0);
    load_thr(20);
    run_eval('{0, 0, 0, 0}, '{1, 1, 1, 1}, 0, 0, 0, 0);
    chk("idle_busy", int'(bus.o_busy), 1);
    @(negedge clk);
    chk("idle_busy_low", int'(bus.o_busy), 0);

    // Snapshot isolation, ignored start, back-to-back, load on CMP edge
    run_eval('{100, 50, 25, 12}, '{1, 2, 3, 4}, 1, 0, 0, 0);
    run_eval('{7, 8, 9, 10}, '{11, 12, 13, 14}, 0, 1, 0, 0);
    load_thr(100);
    run_eval('{255, 0, 0, 0}, '{2, 0, 0, 0}, 0, 0, 1, 300);
    run_eval('{10, 20, 0, 0}, '{3, 4, 0, 0}, 0, 0, 0, 0);

    // Randomized evaluations
    for (int n = 0; n < 24; n++) begin
      bit big;
      if ($urandom_range(0, 3) == 0) load_thr(int'($urandom_range(0, 3000)));
      big = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 4; k++) begin
        t[k] = int'($urandom_range(0, 255));
        w[k] = big ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
      end
      run_eval(t, w, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), int'($urandom_range(0, 1000)));
    end

    // Reset in the middle of accumulation: no completion, outputs back to reset values
    @(negedge clk);
    saved_done = done_cnt;
    bus.i_trace = 32'h00FF_00FF; bus.i_weight = 32'h0101_0101; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_threshold", int'(bus.o_threshold), 500);
    chk("abort_sum", int'(bus.o_sum), 0);
    chk("abort_done", int'(bus.o_done), 0);
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_spike", int'(bus.o_spike), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    thr_m = 500;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt, saved_done);

    // Narrow accumulator: saturation of sum and of threshold
    sat_eval(516);
    bus_s.i_thr_load = 1'b1; bus_s.i_thr_init = AS'(1020);
    @(negedge clk);
    bus_s.i_thr_load = 1'b0;
    sat_eval(1023);
    sat_eval(1023);

    repeat (4) @(negedge clk);
    chk("pending_expect", exp_q.size(), 0);
    chk("done_count", done_cnt, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
